// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage buffers: occupancy states and the
// per-boundary NOP payload words.
package pipe_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_state_t;

    localparam logic [6:0] NOP_INST_TYPE = 7'b0010011;
    localparam logic [4:0] NOP_REG_ADDR  = 5'd0;

    // Builds "addi rd, x0, 0" so a bubble never writes an architectural register.
    function automatic logic [31:0] nop_word(input logic [4:0] rd, input logic [6:0] opcode);
        return {12'd0, 5'd0, 3'd0, rd, opcode};
    endfunction

    localparam logic [31:0] IF_ID_NOP  = nop_word(NOP_REG_ADDR, NOP_INST_TYPE);
    localparam logic [31:0] ID_EX_NOP  = nop_word(NOP_REG_ADDR, NOP_INST_TYPE);
    localparam logic [31:0] EX_MEM_NOP = 32'd0;
    localparam logic [31:0] MEM_WB_NOP = 32'd0;

endpackage

// File: rtl/pipe_stage_ctrl.sv
// Occupancy state machine and valid/ready handshake for one pipeline stage.
// PIPE_STAGE_SKID_EN selects the two-entry skid build; otherwise single-entry.
module pipe_stage_ctrl
    import pipe_pkg::*;
(
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       rdy_in,
    input  logic       flush_in,
    input  logic       up_valid,
    input  logic       dn_ready,
    output logic       up_ready,
    output logic       dn_valid,
    output logic [1:0] occ,
    output logic       load_main,
`ifdef PIPE_STAGE_SKID_EN
    output logic       load_skid,
    output logic       shift_skid,
`endif
    output logic       clear_payload
);

    occ_state_t state;
    occ_state_t next_state;
    logic       up_xfer;
    logic       dn_xfer;

    assign dn_valid = (state != OCC_EMPTY);
    assign occ      = state;
`ifdef PIPE_STAGE_SKID_EN
    // Registered only: the skid entry absorbs the beat in flight when dn_ready drops.
    assign up_ready = (state != OCC_TWO);
`else
    assign up_ready = (state == OCC_EMPTY) | dn_ready;
`endif
    assign up_xfer = up_valid & up_ready & rdy_in & ~flush_in;
    assign dn_xfer = dn_valid & dn_ready & rdy_in;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state <= OCC_EMPTY;
        end else if (rdy_in) begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (flush_in) begin
            next_state = OCC_EMPTY;
        end else begin
            case (state)
                OCC_EMPTY: if (up_xfer) next_state = OCC_ONE;
                OCC_ONE: begin
                    if (dn_xfer && !up_xfer) next_state = OCC_EMPTY;
`ifdef PIPE_STAGE_SKID_EN
                    else if (up_xfer && !dn_xfer) next_state = OCC_TWO;
`endif
                end
                OCC_TWO: if (dn_xfer) next_state = OCC_ONE;
                default: next_state = OCC_EMPTY;
            endcase
        end
    end

    always_comb begin
        load_main     = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
        load_skid     = 1'b0;
        shift_skid    = 1'b0;
`endif
        clear_payload = rdy_in & flush_in;
        case (state)
            OCC_EMPTY: load_main = up_xfer;
            OCC_ONE: begin
                load_main = up_xfer & dn_xfer;
`ifdef PIPE_STAGE_SKID_EN
                load_skid = up_xfer & ~dn_xfer;
`endif
            end
`ifdef PIPE_STAGE_SKID_EN
            OCC_TWO: shift_skid = dn_xfer;
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// Generic valid/ready pipeline stage buffer with flush, pause and NOP fill.
// PIPE_STAGE_SKID_EN adds the skid register for full registered back-pressure.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int                DATA_W  = 32,
    parameter logic [DATA_W-1:0] NOP_VAL = '0
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              flush_in,
    input  logic              up_valid,
    input  logic [DATA_W-1:0] up_data,
    output logic              up_ready,
    output logic              dn_valid,
    output logic [DATA_W-1:0] dn_data,
    input  logic              dn_ready,
    output logic [1:0]        occ
);

    logic              load_main;
    logic              clear_payload;
    logic [DATA_W-1:0] main_q;
`ifdef PIPE_STAGE_SKID_EN
    logic              load_skid;
    logic              shift_skid;
    logic [DATA_W-1:0] skid_q;
`endif

    pipe_stage_ctrl u_ctrl (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .flush_in      (flush_in),
        .up_valid      (up_valid),
        .dn_ready      (dn_ready),
        .up_ready      (up_ready),
        .dn_valid      (dn_valid),
        .occ           (occ),
        .load_main     (load_main),
`ifdef PIPE_STAGE_SKID_EN
        .load_skid     (load_skid),
        .shift_skid    (shift_skid),
`endif
        .clear_payload (clear_payload)
    );

`ifdef PIPE_STAGE_SKID_EN
    always_ff @(posedge clk_in) begin
        if (!rst_in || clear_payload) begin
            main_q <= NOP_VAL;
            skid_q <= NOP_VAL;
        end else begin
            if (load_main) begin
                main_q <= up_data;
            end else if (shift_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= up_data;
            end
        end
    end
`else
    always_ff @(posedge clk_in) begin
        if (!rst_in || clear_payload) begin
            main_q <= NOP_VAL;
        end else if (load_main) begin
            main_q <= up_data;
        end
    end
`endif

    // A drained main register keeps its last beat, so the NOP fill is muxed here.
    assign dn_data = dn_valid ? main_q : NOP_VAL;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf against a queue-based reference model.
// Follows the PIPE_STAGE_SKID_EN setting of the design build.
module tb_pipe_stage_buf;

    localparam int          DATA_W = 32;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              rdy_in;
    logic              flush_in;
    logic              up_valid;
    logic [DATA_W-1:0] up_data;
    logic              up_ready;
    logic              dn_valid;
    logic [DATA_W-1:0] dn_data;
    logic              dn_ready;
    logic [1:0]        occ;

    int checks = 0;
    int passed = 0;

    logic [31:0] model_q[$];
    logic [31:0] src_q[$];
    logic        last_up_x;

    pipe_stage_buf #(.DATA_W(DATA_W), .NOP_VAL(NOP)) dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rdy_in   (rdy_in),
        .flush_in (flush_in),
        .up_valid (up_valid),
        .up_data  (up_data),
        .up_ready (up_ready),
        .dn_valid (dn_valid),
        .dn_data  (dn_data),
        .dn_ready (dn_ready),
        .occ      (occ)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic model_up_ready();
`ifdef PIPE_STAGE_SKID_EN
        return model_q.size() < 2;
`else
        return (model_q.size() == 0) || dn_ready;
`endif
    endfunction

    task automatic checkValue(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) passed++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, act, exp);
    endtask

    task automatic checkOutput();
        logic        exp_valid;
        logic [31:0] exp_data;
        exp_valid = (model_q.size() != 0);
        exp_data  = exp_valid ? model_q[0] : NOP;
        checkValue("dn_valid", {31'd0, dn_valid}, {31'd0, exp_valid});
        checkValue("dn_data", dn_data, exp_data);
        checkValue("occ", {30'd0, occ}, 32'(model_q.size()));
        checkValue("up_ready", {31'd0, up_ready}, {31'd0, model_up_ready()});
    endtask

    // One clock cycle: drive at the falling edge, check, then advance the model.
    task automatic applyStimulus(input logic uv, input logic [31:0] ud, input logic dr,
                                 input logic rdy, input logic fl, input logic rst);
        logic dn_x;
        logic up_x;
        @(negedge clk_in);
        up_valid = uv;
        up_data  = ud;
        dn_ready = dr;
        rdy_in   = rdy;
        flush_in = fl;
        rst_in   = rst;
        #1;
        checkOutput();
        up_x = 1'b0;
        if (!rst) begin
            model_q.delete();
        end else if (rdy) begin
            dn_x = (model_q.size() != 0) && dr;
            up_x = uv && model_up_ready() && !fl;
            if (fl) begin
                model_q.delete();
                up_x = 1'b0;
            end else begin
                if (dn_x) void'(model_q.pop_front());
                if (up_x) model_q.push_back(ud);
            end
        end
        last_up_x = up_x;
    endtask

    task automatic streamStep(input logic dr);
        if (src_q.size() != 0) applyStimulus(1'b1, src_q[0], dr, 1'b1, 1'b0, 1'b1);
        else applyStimulus(1'b0, $urandom, dr, 1'b1, 1'b0, 1'b1);
        if (last_up_x) void'(src_q.pop_front());
    endtask

    initial begin
        logic        have_beat;
        logic [31:0] beat;
        rst_in   = 1'b0;
        rdy_in   = 1'b1;
        flush_in = 1'b0;
        up_valid = 1'b0;
        up_data  = '0;
        dn_ready = 1'b0;
        repeat (2) @(posedge clk_in);

        $display("[TB] streaming");
        for (int i = 1; i <= 8; i++) src_q.push_back(32'(i));
        repeat (11) streamStep(1'b1);

        $display("[TB] back-pressure");
        src_q = '{32'hA0, 32'hA1, 32'hA2};
        streamStep(1'b1);
        repeat (3) streamStep(1'b0);
        repeat (5) streamStep(1'b1);

        $display("[TB] flush");
        src_q = '{32'h10, 32'h11};
        repeat (2) streamStep(1'b0);
        applyStimulus(1'b1, 32'h12, 1'b0, 1'b1, 1'b1, 1'b1);
        src_q.delete();
        repeat (3) streamStep(1'b1);

        $display("[TB] pause");
        src_q = '{32'h55};
        streamStep(1'b0);
        for (int i = 0; i < 3; i++)
            applyStimulus(1'($urandom), 32'h66, 1'(i), 1'b0, 1'(i + 1), 1'b1);
        repeat (2) streamStep(1'b1);

        $display("[TB] reset mid-operation");
        src_q = '{32'h20, 32'h21};
        repeat (2) streamStep(1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h22, 1'b1, 1'b1, 1'b0, 1'b0);
        src_q.delete();
        streamStep(1'b1);

        $display("[TB] random traffic");
        have_beat = 1'b0;
        beat      = '0;
        for (int i = 0; i < 400; i++) begin
            if (!have_beat && ($urandom_range(9) < 7)) begin
                have_beat = 1'b1;
                beat      = $urandom;
            end
            applyStimulus(have_beat, beat, 1'($urandom_range(9) < 6),
                          1'($urandom_range(9) != 0), 1'($urandom_range(19) == 0),
                          1'($urandom_range(49) != 0));
            if (last_up_x) have_beat = 1'b0;
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised pipeline stage buffer for inter-stage boundaries in the RISC-V core (IF/ID, ID/EX, EX/MEM, MEM/WB). It replaces the fixed-payload, stall-vector latches with a generic valid/ready stage that carries a `DATA_W` payload. It holds up to two entries: a main register and a skid register. It supports flush on branch and a global pause, and drives a NOP payload whenever no valid entry is presented.

## Interface
Parameters:
- `DATA_W`, 32: payload width in bits.
- `NOP_VAL`, 0: payload driven on `dn_data` when `dn_valid` is low. Width `DATA_W`.

Ports:
- `clk_in` input 1: single clock. All state updates on the rising edge.
- `rst_in` input 1: reset, synchronous, active-low.
- `rdy_in` input 1: global enable. When low, all state is frozen.
- `flush_in` input 1: branch flush. Kills every held entry and the incoming beat.
- `up_valid` input 1: upstream presents a beat.
- `up_data` input `DATA_W`: upstream payload.
- `up_ready` output 1: stage accepts a beat this cycle.
- `dn_valid` output 1: stage presents a beat.
- `dn_data` output `DATA_W`: downstream payload. Equals `NOP_VAL` when `dn_valid` is 0.
- `dn_ready` input 1: downstream accepts.
- `occ` output 2: number of held entries, 0..2.

## Operation
- Transfer rules: upstream transfer is `up_valid & up_ready & rdy_in & ~flush_in`. Downstream transfer is `dn_valid & dn_ready & rdy_in`.
- State machine, skid build (states EMPTY, ONE, TWO):
  - EMPTY -> ONE on an upstream transfer. The beat is loaded into main.
  - ONE -> EMPTY on a downstream transfer with no upstream transfer.
  - ONE -> ONE when both transfer in the same cycle. Main is reloaded with the new beat.
  - ONE -> TWO on an upstream transfer with no downstream transfer. The beat is loaded into skid.
  - TWO -> ONE on a downstream transfer. Skid moves to main.
  - No upstream transfer is possible in TWO.
- Output: `dn_valid` = state != EMPTY. `dn_data` is driven from main, or `NOP_VAL` in EMPTY.
- `up_ready` = state != TWO. It is taken from registered state only, with no combinational path from `dn_ready`.
- Flush: `flush_in` high with `rdy_in` high forces the next state to EMPTY and sets main and skid to `NOP_VAL`.
  - A downstream transfer in the flush cycle still completes.
  - The upstream beat in the flush cycle is discarded.
- Pause: `rdy_in` low means no transfer and no state change. `flush_in` is ignored.
- Reset: `rst_in` low at a rising edge forces EMPTY and main = skid = `NOP_VAL`. Reset has priority over `rdy_in` and `flush_in`.
- Ordering: beats are strictly FIFO and never duplicated or dropped, except by flush.

## Timing
- Latency is 1 cycle: a beat accepted at edge N is visible on `dn_*` after edge N.
- Throughput is 1 beat/cycle with `dn_ready` held high.
- Back-pressure: when `dn_ready` drops, one further beat is absorbed into skid. `up_ready` falls after the next edge.
- Recovery: when `dn_ready` rises in TWO, `up_ready` rises after that edge.
- Reset values: `dn_valid` = 0, `dn_data` = `NOP_VAL`, `up_ready` = 1, `occ` = 0.
  - `up_ready` reads 1 during reset, but reset blocks transfers.
- Flush at edge N: after N, `dn_valid` = 0 and `occ` = 0. Accepts resume at edge N+1.

## Configuration
- `PIPE_STAGE_SKID_EN` defined (default): two-entry behaviour as described above.
- `PIPE_STAGE_SKID_EN` undefined: single-entry stage.
  - No skid register, and `occ` never exceeds 1.
  - `up_ready` = `~dn_valid | dn_ready`. This is a combinational path from `dn_ready`.
  - Latency is unchanged; throughput is still 1 beat/cycle.
  - Flush, pause and reset rules are unchanged.

## Structure
- Shared package `pipe_pkg`: the occupancy state enum (EMPTY/ONE/TWO) and the NOP payload constants for each boundary, such as the ID/EX NOP word built from the existing `NOPInstType`/`NOPRegAdder` defines.
- Sub-module `pipe_stage_ctrl`: the state machine and the ready/valid/occ logic. It has no payload.
- The top level holds the payload registers and the output mux.

## Test plan
- Streaming: reset, then 8 beats 0x01..0x08 with `dn_ready` = 1. Required: outputs appear 1 cycle later, in order, `occ` stays 1, and `up_ready` stays 1.
- Back-pressure: stream 0xA0, 0xA1, 0xA2 and hold `dn_ready` low from the second cycle. Required: `occ` reaches 2 and `up_ready` falls to 0 with 0xA2 held upstream. After `dn_ready` = 1, the output order is 0xA0, 0xA1, 0xA2.
- Flush: in state TWO (0x10, 0x11 held), assert `flush_in` together with `up_valid` carrying 0x12. Required: next cycle `dn_valid` = 0, `dn_data` = `NOP_VAL`, `occ` = 0, and 0x12 never appears.
- Pause: with 0x55 held, drop `rdy_in` for 3 cycles while toggling `dn_ready`, `flush_in` and `up_valid`. Required: `occ`, `dn_data` and `dn_valid` are unchanged, and 0x55 is delivered after `rdy_in` = 1.
- Reset mid-operation: pull `rst_in` low in state TWO with `flush_in` = 0. Required: after the edge, `occ` = 0, `dn_valid` = 0 and `up_ready` = 1.
- Build without `PIPE_STAGE_SKID_EN`: repeat the back-pressure scenario. Required: `occ` ≤ 1, `up_ready` equals `~dn_valid | dn_ready` every cycle, and order is preserved.
